stage1_pc_addr: RTL and testbench
=================================

// Module: stage1_pc_addr
// PURPOSE
//   Stage-1 (fetch/address) datapath slice of the 16-bit multicycle CPU.
//   Holds the program counter (PC) register, loaded from the ALU result when
//   PCw is asserted. Drives the IorD memory-address mux, which selects PC
//   (instruction fetch) or ALUoutput (data access) as the memory address.
// PARAMETERS
//   WIDTH     16       datapath / address width in bits
//   RESET_PC  16'h0000 PC value loaded by reset
// PORTS
//   CLK        in   1      single system clock; all state updates on rising edge
//   reset      in   1      synchronous, active-low reset (0 = reset)
//   PCw        in   1      PC write enable
//   ALUresult  in   WIDTH  next-PC value (combinational ALU result)
//   IorD       in   2      address-source select
//   ALUoutput  in   WIDTH  registered ALU output (data address)
//   PCout      out  WIDTH  current PC register value
//   IorDout    out  WIDTH  selected memory address
// BEHAVIOUR
//   One clock (CLK); reset is synchronous and active-low.
//   PC register, evaluated on each rising CLK edge, in priority order:
//     - reset==0          -> PC <= RESET_PC (overrides PCw)
//     - reset==1, PCw==1  -> PC <= ALUresult
//     - reset==1, PCw==0  -> PC holds its value
//   PCout = PC (registered); new value is visible one edge after PCw/ALUresult
//     are applied. No combinational path from ALUresult to PCout.
//   Asserting reset mid-operation clears PC at the next edge regardless of PCw;
//     PCout = RESET_PC after that edge.
//   IorDout is purely combinational (zero latency), full WIDTH, no truncation:
//     - IorD=2'b00 -> PC register value (PCout)
//     - IorD=2'b01 -> ALUoutput
//     - IorD=2'b10 -> ALUresult (bypass; for direct-address use)
//     - IorD=2'b11 -> 16'h0000
//   When IorD=00 and PC is written, IorDout follows the new PC after the edge.
//   No handshakes, no FSM; no arithmetic inside the block (PC+1 is done by the ALU).
//   Back-to-back writes on consecutive cycles are supported; each edge with
//     PCw=1 loads the ALUresult present at that edge.
// TESTING
//   1. reset=0 for 1 edge, then reset=1, PCw=0 -> PCout=16'h0000, IorD=00 gives
//      IorDout=16'h0000.
//   2. PCw=1, ALUresult=16'hABCD, 1 edge -> PCout=16'hABCD. Then
//      ALUresult=16'h1234, 1 edge -> PCout=16'h1234.
//   3. Load PC=16'hABCD, then PCw=0, ALUoutput=16'h1234, IorD=01, 1 cycle ->
//      IorDout=16'h1234, PCout stays 16'hABCD.
//   4. Load PC=16'hABCD, then PCw=0, ALUoutput=16'h1234, IorD=00 ->
//      IorDout=16'hABCD.
//   5. PC=16'hABCD, PCw=0, ALUresult=16'h5555 for 3 edges -> PCout stays
//      16'hABCD. IorD=10 -> IorDout=16'h5555. IorD=11 -> IorDout=16'h0000.
//   6. PCw=1, ALUresult=16'hFFFF with reset=0 on the same edge -> PCout=16'h0000
//      (reset wins). Next edge with reset=1 -> PCout=16'hFFFF.

Source files
------------

// File: rtl/stage1_pc_addr.sv
// Fetch/address slice of the 16-bit multicycle CPU: the program counter
// register and the IorD memory-address mux.
module stage1_pc_addr #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             PCw,
    input  logic [WIDTH-1:0] ALUresult,
    input  logic [1:0]       IorD,
    input  logic [WIDTH-1:0] ALUoutput,
    output logic [WIDTH-1:0] PCout,
    output logic [WIDTH-1:0] IorDout
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (PCw) begin
            pc_d = ALUresult;
        end
    end

    // reset is active-low and synchronous, and it overrides any PC write
    always_ff @(posedge CLK) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCout = pc_q;

    // Zero-latency address select; 2'b10 bypasses the live ALU result
    always_comb begin
        IorDout = '0;
        unique case (IorD)
            2'b00:   IorDout = pc_q;
            2'b01:   IorDout = ALUoutput;
            2'b10:   IorDout = ALUresult;
            default: IorDout = '0;
        endcase
    end

endmodule

// File: tb/tb_stage1_pc_addr.sv
// Self-checking bench for stage1_pc_addr: directed steps followed by a
// randomized run against a simple behavioural PC/mux model.
module tb_stage1_pc_addr;

    localparam int          WIDTH    = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic             clk;
    logic             reset;
    logic             pc_w;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       iord;
    logic [WIDTH-1:0] alu_output;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] iord_out;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_pc;
    bit               model_pc_valid = 0;

    stage1_pc_addr #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK       (clk),
        .reset     (reset),
        .PCw       (pc_w),
        .ALUresult (alu_result),
        .IorD      (iord),
        .ALUoutput (alu_output),
        .PCout     (pc_out),
        .IorDout   (iord_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected memory address straight from the select table
    function automatic logic [WIDTH-1:0] expected_addr(input logic [1:0] sel,
                                                       input logic [WIDTH-1:0] pc,
                                                       input logic [WIDTH-1:0] aluo,
                                                       input logic [WIDTH-1:0] alur);
        if (sel == 2'd0) return pc;
        if (sel == 2'd1) return aluo;
        if (sel == 2'd2) return alur;
        return 16'h0000;
    endfunction

    task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                                input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs after the falling edge, check the mux before the
    // rising edge, then check PC and mux shortly after it.
    task automatic apply_stimulus(input string tag, input logic rst_n, input logic we,
                                  input logic [WIDTH-1:0] alur, input logic [1:0] sel,
                                  input logic [WIDTH-1:0] aluo);
        @(negedge clk);
        reset      = rst_n;
        pc_w       = we;
        alu_result = alur;
        iord       = sel;
        alu_output = aluo;
        #1;
        if (model_pc_valid || sel != 2'b00)
            check_output({tag, "_addr_pre"}, iord_out, expected_addr(sel, model_pc, aluo, alur));
        @(posedge clk);
        if (!rst_n) begin
            model_pc       = RESET_PC;
            model_pc_valid = 1;
        end else if (we) begin
            model_pc       = alur;
            model_pc_valid = 1;
        end
        #1;
        if (model_pc_valid) begin
            check_output({tag, "_pc"}, pc_out, model_pc);
            check_output({tag, "_addr_post"}, iord_out, expected_addr(sel, model_pc, aluo, alur));
        end
    endtask

    initial begin
        reset      = 1'b0;
        pc_w       = 1'b0;
        alu_result = '0;
        iord       = 2'b00;
        alu_output = '0;

        // Reset state
        apply_stimulus("rst", 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
        apply_stimulus("rst_idle", 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000);
        check_output("rst_pc_const", pc_out, 16'h0000);

        // Back-to-back loads
        apply_stimulus("ld_abcd", 1'b1, 1'b1, 16'hABCD, 2'b00, 16'h0000);
        check_output("ld_abcd_const", pc_out, 16'hABCD);
        apply_stimulus("ld_1234", 1'b1, 1'b1, 16'h1234, 2'b00, 16'h0000);
        check_output("ld_1234_const", pc_out, 16'h1234);

        // Data address vs PC address
        apply_stimulus("ld_abcd2", 1'b1, 1'b1, 16'hABCD, 2'b00, 16'h0000);
        apply_stimulus("sel01", 1'b1, 1'b0, 16'h0000, 2'b01, 16'h1234);
        check_output("sel01_const", iord_out, 16'h1234);
        check_output("sel01_pc_const", pc_out, 16'hABCD);
        apply_stimulus("sel00", 1'b1, 1'b0, 16'h0000, 2'b00, 16'h1234);
        check_output("sel00_const", iord_out, 16'hABCD);

        // Hold for three edges, then bypass and zero selects
        apply_stimulus("hold1", 1'b1, 1'b0, 16'h5555, 2'b00, 16'h1234);
        apply_stimulus("hold2", 1'b1, 1'b0, 16'h5555, 2'b00, 16'h1234);
        apply_stimulus("hold3", 1'b1, 1'b0, 16'h5555, 2'b10, 16'h1234);
        check_output("hold_pc_const", pc_out, 16'hABCD);
        check_output("sel10_const", iord_out, 16'h5555);
        apply_stimulus("sel11", 1'b1, 1'b0, 16'h5555, 2'b11, 16'h1234);
        check_output("sel11_const", iord_out, 16'h0000);

        // Reset beats a simultaneous write, then the write lands
        apply_stimulus("rst_vs_w", 1'b0, 1'b1, 16'hFFFF, 2'b00, 16'h0000);
        check_output("rst_vs_w_const", pc_out, 16'h0000);
        apply_stimulus("w_after_rst", 1'b1, 1'b1, 16'hFFFF, 2'b00, 16'h0000);
        check_output("w_after_rst_const", pc_out, 16'hFFFF);

        // Randomized operation
        for (int i = 0; i < 300; i++) begin
            apply_stimulus($sformatf("rnd%0d", i),
                           ($urandom_range(0, 15) != 0),
                           1'($urandom_range(0, 1)),
                           16'($urandom),
                           2'($urandom_range(0, 3)),
                           16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
